// File: rtl/fix2flt_seq.sv
// Signed fixed point to binary float converter, one normalising shift per clock.
// Latency: k+2 cycles from the accepting edge, where k is the number of left shifts.
// Backpressure: start is ignored while busy; there is no stall on the result side.
module fix2flt_seq #(
  parameter int IN_W   = 16,
  parameter int FRAC_W = 8,
  parameter int EXP_W  = 5,
  parameter int MAN_W  = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [IN_W-1:0]          din,
  output logic                     busy,
  output logic                     done,
  output logic [EXP_W+MAN_W:0]     dout,
  output logic                     inexact,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int EW     = EXP_W + 2;
  localparam int BIAS   = (2 ** (EXP_W - 1)) - 1;
  localparam int E_INIT = BIAS + IN_W - 1 - FRAC_W;
  localparam int E_MAX  = (2 ** EXP_W) - 1;
  // Magnitude bits below the hidden bit, padded so guard/sticky always exist.
  localparam int FW     = IN_W + MAN_W;

  localparam logic signed [EW-1:0] E_INIT_S = EW'(E_INIT);
  localparam logic signed [EW-1:0] E_MAX_S  = EW'(E_MAX);
  localparam logic signed [EW-1:0] E_ONE_S  = EW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_NORM  = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;

  logic [1:0]              state;
  logic                    sgn;
  logic [IN_W-1:0]         mag;
  logic signed [EW-1:0]    e;
  logic                    zflag;
  logic                    uflag;

  logic [FW-1:0]           ext;
  logic [MAN_W-1:0]        m;
  logic                    g;
  logic                    s;
  logic                    inc;
  logic [MAN_W:0]          m_sum;
  logic signed [EW-1:0]    e_fin;
  logic                    ovf;
  logic [EXP_W+MAN_W:0]    res;

  assign busy = (state != S_IDLE);

  // Round-to-nearest-even of the normalised magnitude and result packing.
  always_comb begin
    ext   = {mag[IN_W-2:0], {(MAN_W + 1){1'b0}}};
    m     = ext[FW-1 -: MAN_W];
    g     = ext[FW-1-MAN_W];
    s     = |ext[FW-2-MAN_W:0];
    inc   = g & (s | m[0]);
    m_sum = {1'b0, m} + {{MAN_W{1'b0}}, inc};
    e_fin = e + {{(EW-1){1'b0}}, m_sum[MAN_W]};
    ovf   = !zflag && (e_fin >= E_MAX_S);
    if (zflag)
      res = {sgn & uflag, {(EXP_W + MAN_W){1'b0}}};
    else if (ovf)
      res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else
      res = {sgn, e_fin[EXP_W-1:0], m_sum[MAN_W-1:0]};
  end

  // Control FSM: capture, normalise one bit per cycle, round and publish.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      sgn       <= 1'b0;
      mag       <= '0;
      e         <= '0;
      zflag     <= 1'b0;
      uflag     <= 1'b0;
      done      <= 1'b0;
      dout      <= '0;
      inexact   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            sgn   <= din[IN_W-1];
            // Most-negative input negates to itself, which is the correct magnitude unsigned.
            mag   <= din[IN_W-1] ? (~din + 1'b1) : din;
            e     <= E_INIT_S;
            zflag <= (din == '0);
            uflag <= 1'b0;
            // Zero also passes through NORM so the minimum latency is uniform.
            state <= S_NORM;
          end
        end
        S_NORM: begin
          if (zflag || mag[IN_W-1]) begin
            state <= S_ROUND;
          end else if (e == E_ONE_S) begin
            zflag <= 1'b1;
            uflag <= 1'b1;
            state <= S_ROUND;
          end else begin
            mag <= {mag[IN_W-2:0], 1'b0};
            e   <= e - E_ONE_S;
          end
        end
        S_ROUND: begin
          dout      <= res;
          inexact   <= g | s | ovf;
          overflow  <= ovf;
          underflow <= uflag;
          done      <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fix2flt_seq.sv
// Directed bench for fix2flt_seq: three parameterisations, hand-computed results.
module tb_fix2flt_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        st [3];
  logic [15:0] di [3];

  logic       b0, dn0, ix0, ov0, uf0;
  logic [15:0] do0;
  logic       b1, dn1, ix1, ov1, uf1;
  logic [7:0] do1;
  logic       b2, dn2, ix2, ov2, uf2;
  logic [5:0] do2;

  fix2flt_seq #(.IN_W(16), .FRAC_W(8), .EXP_W(5), .MAN_W(10)) d0 (
    .clk(clk), .reset(rst), .start(st[0]), .din(di[0]), .busy(b0), .done(dn0),
    .dout(do0), .inexact(ix0), .overflow(ov0), .underflow(uf0));
  fix2flt_seq #(.IN_W(16), .FRAC_W(0), .EXP_W(4), .MAN_W(3)) d1 (
    .clk(clk), .reset(rst), .start(st[1]), .din(di[1]), .busy(b1), .done(dn1),
    .dout(do1), .inexact(ix1), .overflow(ov1), .underflow(uf1));
  fix2flt_seq #(.IN_W(16), .FRAC_W(15), .EXP_W(3), .MAN_W(2)) d2 (
    .clk(clk), .reset(rst), .start(st[2]), .din(di[2]), .busy(b2), .done(dn2),
    .dout(do2), .inexact(ix2), .overflow(ov2), .underflow(uf2));

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic snap(input int i, output logic bz, output logic dn, output logic [15:0] dv,
                      output logic ix, output logic ov, output logic uf);
    case (i)
      0:       begin bz = b0; dn = dn0; dv = do0;         ix = ix0; ov = ov0; uf = uf0; end
      1:       begin bz = b1; dn = dn1; dv = {8'h0, do1}; ix = ix1; ov = ov1; uf = uf1; end
      default: begin bz = b2; dn = dn2; dv = {10'h0, do2}; ix = ix2; ov = ov2; uf = uf2; end
    endcase
  endtask

  // One conversion: latency counted in edges after the accepting edge.
  task automatic run(input int i, input logic [15:0] x, input logic [15:0] exp_d,
                     input int exp_lat, input logic exp_ix, input logic exp_ov,
                     input logic exp_uf, input string tag);
    logic bz, dn, ix, ov, uf;
    logic [15:0] dv;
    int n;
    @(negedge clk);
    di[i] = x;
    st[i] = 1'b1;
    @(posedge clk);
    #1 st[i] = 1'b0;
    snap(i, bz, dn, dv, ix, ov, uf);
    check({tag, "/busy"}, 32'(bz), 32'd1);
    n = 0;
    dn = 1'b0;
    while (!dn && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      snap(i, bz, dn, dv, ix, ov, uf);
    end
    check({tag, "/done"}, 32'(dn), 32'd1);
    check({tag, "/lat"}, 32'(n), 32'(exp_lat));
    check({tag, "/dout"}, 32'(dv), 32'(exp_d));
    check({tag, "/inexact"}, 32'(ix), 32'(exp_ix));
    check({tag, "/overflow"}, 32'(ov), 32'(exp_ov));
    check({tag, "/underflow"}, 32'(uf), 32'(exp_uf));
    @(posedge clk);
    #1 check({tag, "/pulse"}, 32'(dn0 | dn1 | dn2), 32'd0);
  endtask

  initial begin
    int cnt;
    int n;
    logic [15:0] last;
    for (int i = 0; i < 3; i++) begin st[i] = 1'b0; di[i] = 16'h0; end
    rst = 1'b1;
    #12;
    check("rst/busy", 32'(b0), 32'd0);
    check("rst/done", 32'(dn0), 32'd0);
    check("rst/dout", 32'(do0), 32'd0);
    check("rst/flags", {29'd0, ix0, ov0, uf0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run(0, 16'h0100, 16'h3C00, 9,  1'b0, 1'b0, 1'b0, "one");
    run(0, 16'hFF00, 16'hBC00, 9,  1'b0, 1'b0, 1'b0, "minus_one");
    run(0, 16'h8000, 16'hD800, 2,  1'b0, 1'b0, 1'b0, "most_neg");
    run(0, 16'h0000, 16'h0000, 2,  1'b0, 1'b0, 1'b0, "zero");
    run(0, 16'h0001, 16'h1C00, 17, 1'b0, 1'b0, 1'b0, "lsb");
    run(0, 16'h7FFF, 16'h5800, 3,  1'b1, 1'b0, 1'b0, "carry");
    run(0, 16'h2004, 16'h5000, 4,  1'b1, 1'b0, 1'b0, "tie_down");
    run(0, 16'h200C, 16'h5002, 4,  1'b1, 1'b0, 1'b0, "tie_up");
    run(1, 16'h7FFF, 16'h0078, 3,  1'b1, 1'b1, 1'b0, "ovf");
    run(1, 16'h0001, 16'h0038, 17, 1'b0, 1'b0, 1'b0, "ovf_clear");
    run(2, 16'h0001, 16'h0000, 4,  1'b1, 1'b0, 1'b1, "flush_pos");
    run(2, 16'hFFFF, 16'h0020, 4,  1'b1, 1'b0, 1'b1, "flush_neg");

    // start pulsed during NORM must not disturb the running conversion.
    @(negedge clk);
    di[0] = 16'h0001;
    st[0] = 1'b1;
    @(posedge clk);
    #1 st[0] = 1'b0;
    cnt = 0;
    last = 16'h0;
    for (int c = 0; c < 25; c++) begin
      if (c == 4) begin st[0] = 1'b1; di[0] = 16'h0100; end
      if (c == 5) st[0] = 1'b0;
      @(posedge clk);
      #1;
      if (dn0) begin cnt++; last = do0; end
    end
    check("ignore/count", 32'(cnt), 32'd1);
    check("ignore/dout", 32'(last), 32'h1C00);

    // Asynchronous reset in the middle of a conversion.
    @(negedge clk);
    di[0] = 16'h0001;
    st[0] = 1'b1;
    @(posedge clk);
    #1 st[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst/busy", 32'(b0), 32'd0);
    check("arst/done", 32'(dn0), 32'd0);
    check("arst/dout", 32'(do0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (dn0) cnt++;
    end
    check("arst/no_done", 32'(cnt), 32'd0);
    run(0, 16'h0100, 16'h3C00, 9, 1'b0, 1'b0, 1'b0, "after_rst");

    // Back-to-back with start held high.
    @(negedge clk);
    di[0] = 16'h0100;
    st[0] = 1'b1;
    @(posedge clk);
    n = 0;
    #1;
    while (!dn0 && n < 40) begin @(posedge clk); #1; n++; end
    check("b2b/first_done", 32'(dn0), 32'd1);
    check("b2b/first_dout", 32'(do0), 32'h3C00);
    check("b2b/idle_at_done", 32'(b0), 32'd0);
    di[0] = 16'hFF00;
    @(posedge clk);
    #1;
    check("b2b/accept", 32'(b0), 32'd1);
    st[0] = 1'b0;
    n = 0;
    while (!dn0 && n < 40) begin @(posedge clk); #1; n++; end
    check("b2b/second_done", 32'(dn0), 32'd1);
    check("b2b/second_lat", 32'(n), 32'd9);
    check("b2b/second_dout", 32'(do0), 32'hBC00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
